// File: rtl/bp_dout_accum_pkg.sv
// Shared definitions for the LSTM backprop dout path: default sizes, FSM encoding and
// the overflow helper used by the saturating adder.
package bp_dout_accum_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_NUM_CELL   = 8;
  localparam int unsigned DEF_NUM_TERM   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StDone
  } state_e;

  // Signed overflow of a one-bit-widened sum: guard and sign bits disagree.
  function automatic logic sat_ovf(input logic guard, input logic sign);
    return guard ^ sign;
  endfunction

endpackage

// File: rtl/bp_dout_accum_sat_add.sv
// Combinational signed saturating adder; clamps to the DATA_WIDTH range and flags the clamp.
module sat_add_signed
  import bp_dout_accum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sum,
  output logic                         ovf
);

  localparam logic [DATA_WIDTH-1:0] MaxVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0] wide;

  always_comb begin
    wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    ovf  = sat_ovf(wide[DATA_WIDTH], wide[DATA_WIDTH-1]);
    sum  = ovf ? (wide[DATA_WIDTH] ? MinVal : MaxVal) : wide[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/bp_dout_accum.sv
// Per-timestep dout accumulation buffer: counts NUM_CELL*NUM_TERM contributions and sums
// them with saturation into a per-cell register file with a registered read port.
module bp_dout_accum
  import bp_dout_accum_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_CELL   = DEF_NUM_CELL,
  parameter int unsigned NUM_TERM   = DEF_NUM_TERM,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned Total = NUM_CELL * NUM_TERM;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam int unsigned IdxW  = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;

  state_e state_q, state_d;

  logic [CntW-1:0]       cnt_q;
  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_CELL];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  err_q;

  logic                  accept;
  logic                  s1_in_range, rd_in_range;
  logic [IdxW-1:0]       s1_idx, rd_idx;
  logic [DATA_WIDTH-1:0] sum;
  logic                  ovf;

  assign accept      = o_ready && i_valid && !i_clr;
  assign s1_in_range = s1_addr_q < ADDR_WIDTH'(NUM_CELL);
  assign rd_in_range = i_rd_addr < ADDR_WIDTH'(NUM_CELL);
  assign s1_idx      = s1_addr_q[IdxW-1:0];
  assign rd_idx      = i_rd_addr[IdxW-1:0];

  sat_add_signed #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_add (
    .a  (mem_q[s1_idx]),
    .b  (s1_data_q),
    .sum(sum),
    .ovf(ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = StAccum;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StAccum: if (accept && cnt_q == CntW'(Total - 1)) state_d = StDrain;
        StDrain: state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == StAccum);
    o_done  = (state_q == StDone);
  end

  // s1 retires the beat accepted last cycle, so a back-to-back beat to the same cell
  // always reads the entry already updated by its predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_CELL; i++) mem_q[i] <= '0;
    end else begin
      rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
      if (i_clr) begin
        cnt_q      <= '0;
        s1_valid_q <= 1'b0;
        err_q      <= 1'b0;
        for (int i = 0; i < NUM_CELL; i++) mem_q[i] <= '0;
      end else begin
        s1_valid_q <= accept;
        if (accept) begin
          cnt_q     <= cnt_q + CntW'(1);
          s1_addr_q <= i_addr;
          s1_data_q <= i_data;
        end
        if (s1_valid_q) begin
          if (s1_in_range) begin
            mem_q[s1_idx] <= sum;
            if (ovf) err_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign o_rd_data = rd_data_q;
  assign o_err     = err_q;

endmodule
